// File: rtl/aes_pkg.sv
// AES-128 shared definitions: S-box, Rcon,
// GF(2^8) helpers and FSM state type.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the table.
  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column is {a0,a1,a2,a3}, a0 in the top byte.
  function automatic logic [31:0] mix_column(
    input logic [31:0] col
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES round plus next
// round key derivation.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] data,
  input  logic [127:0] key,
  input  logic [7:0]   rc,
  input  logic         last,
  output logic [127:0] data_nxt,
  output logic [127:0] key_nxt
);

  logic [7:0]  sb [16];
  logic [7:0]  sr [16];
  logic [31:0] mc [4];
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] tmp;
  logic [31:0] n0, n1, n2, n3;
  logic [127:0] state;

  // Expand the next round key from the current one.
  always_comb begin
    w0 = key[127:96];
    w1 = key[95:64];
    w2 = key[63:32];
    w3 = key[31:0];
    tmp = sub_word({w3[23:0], w3[31:24]})
        ^ {rc, 24'h000000};
    n0 = w0 ^ tmp;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    key_nxt = {n0, n1, n2, n3};
  end

  // SubBytes, ShiftRows, MixColumns, AddRoundKey.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(data[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[r+4*c] = sb[r+4*((c+r)%4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[c] = mix_column({sr[4*c], sr[4*c+1],
                          sr[4*c+2], sr[4*c+3]});
    end
    state = '0;
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        state[127-32*c -: 32] = {sr[4*c], sr[4*c+1],
                                 sr[4*c+2], sr[4*c+3]};
      end else begin
        state[127-32*c -: 32] = mc[c];
      end
    end
    data_nxt = state ^ key_nxt;
  end

endmodule

// File: rtl/aes_engine.sv
// Iterative AES-128 encryption core,
// one round per clock.
module aes_engine
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] anahtar,
  input  logic [127:0] blok,
  input  logic         g_gecerli,
  output logic         hazir,
  output logic [127:0] sifre,
  output logic         c_gecerli
);

  state_t       state_q;
  state_t       state_d;
  logic [3:0]   round_q;
  logic [127:0] data_q;
  logic [127:0] key_q;
  logic [127:0] rnd_data;
  logic [127:0] rnd_key;
  logic         running;
  logic         last;
  logic         accept;

  aes_round u_round (
    .data     (data_q),
    .key      (key_q),
    .rc       (rcon(round_q)),
    .last     (last),
    .data_nxt (rnd_data),
    .key_nxt  (rnd_key)
  );

  // A stray counter value outside 1..10 behaves as idle.
  always_comb begin
    running = (state_q == BUSY)
           && (round_q >= 4'd1)
           && (round_q <= 4'(NR));
    last = running && (round_q == 4'(NR));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    if (!running) begin
      state_d = g_gecerli ? BUSY : IDLE;
    end else if (last) begin
      state_d = IDLE;
    end
  end

  // FSM outputs: ready and accept strobe.
  always_comb begin
    hazir  = !running;
    accept = hazir && g_gecerli;
  end

  // Round datapath, key and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      key_q   <= '0;
      round_q <= '0;
    end else if (accept) begin
      data_q  <= blok ^ anahtar;
      key_q   <= anahtar;
      round_q <= 4'd1;
    end else if (running) begin
      data_q  <= rnd_data;
      key_q   <= rnd_key;
      round_q <= last ? 4'd0 : round_q + 4'd1;
    end
  end

  // Result register and completion strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sifre     <= '0;
      c_gecerli <= 1'b0;
    end else begin
      c_gecerli <= last;
      if (last) sifre <= rnd_data;
    end
  end

endmodule

// File: tb/tb_aes_engine.sv
// Directed bench for aes_engine using
// FIPS-197 and zero-key vectors.
module tb_aes_engine;

  logic         clk;
  logic         rst;
  logic [127:0] anahtar;
  logic [127:0] blok;
  logic         g_gecerli;
  logic         hazir;
  logic [127:0] sifre;
  logic         c_gecerli;

  int vecs;
  int miss;

  localparam logic [127:0] K1 =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 =
    128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 =
    128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C0 =
    128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_engine dut (
    .clk       (clk),
    .rst       (rst),
    .anahtar   (anahtar),
    .blok      (blok),
    .g_gecerli (g_gecerli),
    .hazir     (hazir),
    .sifre     (sifre),
    .c_gecerli (c_gecerli)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // One isolated block; optionally scramble inputs while busy.
  task automatic run_block(
    input string        tag,
    input logic [127:0] k,
    input logic [127:0] p,
    input logic [127:0] c,
    input bit           scramble
  );
    int first;
    int pulses;
    logic [127:0] got;
    first  = 0;
    pulses = 0;
    got    = '0;
    @(negedge clk);
    anahtar   = k;
    blok      = p;
    g_gecerli = 1'b1;
    chk({tag, "_rdy"}, 128'(hazir), 128'd1);
    @(posedge clk);
    #1;
    g_gecerli = 1'b0;
    chk({tag, "_busy"}, 128'(hazir), 128'd0);
    if (scramble) begin
      anahtar = ~k;
      blok    = ~p;
    end
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk);
      #1;
      if (c_gecerli) begin
        if (first == 0) first = i;
        pulses++;
        got = sifre;
      end
    end
    chk({tag, "_lat"}, 128'(first), 128'd10);
    chk({tag, "_width"}, 128'(pulses), 128'd1);
    chk({tag, "_ct"}, got, c);
    chk({tag, "_hold"}, sifre, c);
  endtask

  initial begin
    int pos [3];
    logic [127:0] res [3];
    int np;
    vecs      = 0;
    miss      = 0;
    rst       = 1'b0;
    anahtar   = '0;
    blok      = '0;
    g_gecerli = 1'b0;

    // Reset state
    #12;
    chk("rst_hazir", 128'(hazir), 128'd1);
    chk("rst_cv", 128'(c_gecerli), 128'd0);
    chk("rst_sifre", sifre, 128'd0);
    @(negedge clk);
    rst = 1'b1;

    // Known-answer vectors
    run_block("fips_c1", K1, P1, C1, 1'b0);
    run_block("fips_b", K2, P2, C2, 1'b0);
    run_block("zero", '0, '0, C0, 1'b0);
    run_block("scram", K2, P2, C2, 1'b1);

    // Back-to-back with g_gecerli held high
    np = 0;
    @(negedge clk);
    anahtar   = K1;
    blok      = P1;
    g_gecerli = 1'b1;
    @(posedge clk);
    #1;
    anahtar = K2;
    blok    = P2;
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk);
      #1;
      if (c_gecerli) begin
        chk("b2b_rdy", 128'(hazir), 128'd1);
        if (np < 3) begin
          pos[np] = i;
          res[np] = sifre;
        end
        np++;
      end
      if (i == 11) begin
        anahtar = '0;
        blok    = '0;
      end
      if (i == 22) g_gecerli = 1'b0;
    end
    chk("b2b_count", 128'(np), 128'd3);
    if (np == 3) begin
      chk("b2b_pos0", 128'(pos[0]), 128'd10);
      chk("b2b_pos1", 128'(pos[1]), 128'd21);
      chk("b2b_pos2", 128'(pos[2]), 128'd32);
      chk("b2b_ct0", res[0], C1);
      chk("b2b_ct1", res[1], C2);
      chk("b2b_ct2", res[2], C0);
    end

    // Reset in the middle of a block
    repeat (3) @(posedge clk);
    @(negedge clk);
    anahtar   = K1;
    blok      = P1;
    g_gecerli = 1'b1;
    @(posedge clk);
    #1;
    g_gecerli = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_sifre", sifre, 128'd0);
    chk("mid_cv", 128'(c_gecerli), 128'd0);
    chk("mid_hazir", 128'(hazir), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    np = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (c_gecerli) np++;
    end
    chk("mid_nopulse", 128'(np), 128'd0);
    chk("mid_rdy", 128'(hazir), 128'd1);
    chk("mid_still0", sifre, 128'd0);
    run_block("after_rst", K1, P1, C1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
